// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C link: FSM state encodings, R/W bit values
// and the default bus address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6
  } i2c_state_e;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h52;

endpackage

// File: rtl/i2c_if.sv
// Bus-pin bundle for an I2C node: SCL/SDA as seen on the pins plus the
// open-drain pull-down enable for SDA.
interface i2c_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises asynchronous SCL/SDA and derives SCL edge pulses and
// START/STOP conditions from the synchronised levels.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl_s;
      r_sda_d    <= sda_s;
    end
  end

  assign w_scl_s   = r_scl_sync[SYNC_STAGES-1];
  assign sda_s     = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  = w_scl_s & ~r_scl_d;
  assign scl_fall  = ~w_scl_s & r_scl_d;
  assign start_det = w_scl_s & r_scl_d & r_sda_d & ~sda_s;
  assign stop_det  = w_scl_s & r_scl_d & ~r_sda_d & sda_s;

endmodule

// File: rtl/i2c_target.sv
// Clk-synchronous I2C target: address match, byte receive and byte transmit
// over an open-drain SDA, without clock stretching.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  i2c_if.slave       bus,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  output logic       rw_dir,
  output logic       busy,
  output logic [2:0] state
);

  logic       w_scl_rise, w_scl_fall, w_sda_s, w_start_det, w_stop_det;
  logic       w_addr_match;

  i2c_state_e r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_rw_dir, w_rw_dir_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_tx_hold, w_tx_hold_nxt;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .sda_s     (w_sda_s),
    .start_det (w_start_det),
    .stop_det  (w_stop_det)
  );

  assign w_addr_match = (r_shift[7:1] == TARGET_ADDR) && (r_shift[7:1] != 7'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw_dir   <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_hold  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_rw_dir   <= w_rw_dir_nxt;
      r_busy     <= w_busy_nxt;
      r_tx_hold  <= w_tx_hold_nxt;
    end
  end

  // In the ACK states r_sda_oe doubles as the phase flag: the first scl_fall
  // starts the ACK pulse, the second one ends it.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_rx_data_nxt  = r_rx_data;
    w_sda_oe_nxt   = r_sda_oe;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_rw_dir_nxt   = r_rw_dir;
    w_busy_nxt     = r_busy;
    w_tx_hold_nxt  = r_tx_hold;
    if (w_start_det) begin
      w_state_nxt   = ADDR;
      w_cnt_nxt     = 3'd0;
      w_shift_nxt   = 8'h00;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b1;
      w_tx_hold_nxt = 1'b0;
    end else if (w_stop_det) begin
      w_state_nxt   = IDLE;
      w_cnt_nxt     = 3'd0;
      w_sda_oe_nxt  = 1'b0;
      w_busy_nxt    = 1'b0;
      w_tx_hold_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR: if (w_scl_rise) begin
          w_shift_nxt = {r_shift[6:0], w_sda_s};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) w_state_nxt = ADDR_ACK;
        end
        ADDR_ACK: if (w_scl_fall) begin
          if (r_sda_oe) begin
            w_cnt_nxt = 3'd0;
            if (r_rw_dir == I2C_READ) begin
              w_state_nxt  = TX;
              w_sda_oe_nxt = ~r_shift[7];
            end else begin
              w_state_nxt  = RX;
              w_sda_oe_nxt = 1'b0;
            end
          end else if (w_addr_match) begin
            w_sda_oe_nxt = 1'b1;
            w_rw_dir_nxt = r_shift[0];
            if (r_shift[0] == I2C_READ) begin
              w_shift_nxt  = tx_data;
              w_tx_req_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
          end
        end
        RX: if (w_scl_rise) begin
          w_shift_nxt = {r_shift[6:0], w_sda_s};
          w_cnt_nxt   = r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            w_rx_data_nxt  = {r_shift[6:0], w_sda_s};
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = RX_ACK;
          end
        end
        RX_ACK: if (w_scl_fall) begin
          w_sda_oe_nxt = ~r_sda_oe;
          if (r_sda_oe) w_state_nxt = RX;
        end
        TX: if (w_scl_fall) begin
          if (r_tx_hold) begin
            w_sda_oe_nxt  = ~r_shift[7];
            w_tx_hold_nxt = 1'b0;
          end else if (r_cnt == 3'd7) begin
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd0;
            w_state_nxt  = TX_ACK;
          end else begin
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_cnt_nxt    = r_cnt + 3'd1;
            w_sda_oe_nxt = ~r_shift[6];
          end
        end
        TX_ACK: if (w_scl_rise) begin
          if (!w_sda_s) begin
            w_shift_nxt   = tx_data;
            w_tx_req_nxt  = 1'b1;
            w_tx_hold_nxt = 1'b1;
            w_cnt_nxt     = 3'd0;
            w_state_nxt   = TX;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Byte side: rx_valid and tx_req are single-clk strobes with no back-pressure;
  // tx_data is sampled on the clk that raises tx_req and must hold the next byte
  // before the following tx_req.
  assign bus.sda_oe = r_sda_oe;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign tx_req     = r_tx_req;
  assign rw_dir     = r_rw_dir;
  assign busy       = r_busy;
  assign state      = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level initiator driver, a frame-level
// model of what the target must drive, and one negedge compare process.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int         Q       = 4;
  localparam logic [6:0] TB_ADDR = 7'h52;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_data = 8'h3C;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, rw_dir, busy;
  logic [2:0] state;

  i2c_if bus ();
  assign bus.scl_in = scl;
  assign bus.sda_in = ~(bus.sda_oe | m_low);

  i2c_target #(.TARGET_ADDR(TB_ADDR), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .tx_data  (tx_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .rw_dir   (rw_dir),
    .busy     (busy),
    .state    (state)
  );

  // ---------------- scoreboard / compare process ----------------
  int          vectors = 0;
  int          fails = 0;
  int          tx_req_cnt = 0;
  logic        chk_en = 1'b0;
  logic        exp_oe = 1'b0;
  logic        ck_req = 1'b0;
  string       ck_name = "";
  logic [31:0] ck_got = '0;
  logic [31:0] ck_want = '0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_b;
  logic [7:0]  tx_table [4] = '{8'h3C, 8'hC3, 8'h3C, 8'h00};

  always @(negedge clk) begin
    if (ck_req) begin
      vectors++;
      if (ck_got !== ck_want) begin
        fails++;
        $display("FAIL %s: got %0h want %0h", ck_name, ck_got, ck_want);
      end
    end
    if (chk_en) begin
      vectors++;
      if (bus.sda_oe !== exp_oe) begin
        fails++;
        $display("FAIL sda_oe @%0t: got %b want %b", $time, bus.sda_oe, exp_oe);
      end
    end
    if (rx_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rx_valid_unexpected: got rx_data %h want no pulse", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          fails++;
          $display("FAIL rx_data: got %h want %h", rx_data, exp_b);
        end
      end
    end
    // Local side: present the next table byte once the current one is consumed.
    if (tx_req) begin
      tx_req_cnt++;
      tx_data = (tx_req_cnt < 4) ? tx_table[tx_req_cnt] : 8'h00;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    ck_name = name;
    ck_got  = got;
    ck_want = want;
    ck_req  = 1'b1;
    @(negedge clk);
    #1;
    ck_req  = 1'b0;
  endtask

  function automatic logic model_match(input logic [6:0] a);
    return (a == TB_ADDR) && (a != 7'h00);
  endfunction

  // One SCL period; drv is the level the target must pull during SCL high.
  task automatic xfer_bit(input logic b, input logic drv, output logic seen);
    scl = 1'b0;
    tick(Q);
    m_low  = ~b;
    exp_oe = drv;
    tick(Q);
    scl    = 1'b1;
    chk_en = 1'b1;
    tick(Q);
    seen = bus.sda_in;
    tick(Q);
    chk_en = 1'b0;
  endtask

  task automatic bus_start();
    scl = 1'b0;
    tick(Q);
    m_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    m_low = 1'b1;
    tick(2 * Q);
  endtask

  task automatic bus_stop();
    scl = 1'b0;
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(2 * Q);
    m_low = 1'b0;
    tick(2 * Q);
  endtask

  task automatic addr_phase(input logic [6:0] a, input logic rd, output logic acked);
    logic [7:0] f;
    logic       seen;
    f = {a, rd};
    for (int i = 7; i >= 0; i--) xfer_bit(f[i], 1'b0, seen);
    xfer_bit(1'b1, model_match(a), seen);
    acked = ~seen;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic matched);
    logic seen;
    if (matched) exp_q.push_back(d);
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], 1'b0, seen);
    xfer_bit(1'b1, matched, seen);
  endtask

  task automatic read_byte(input logic [7:0] model_b, input logic ack, output logic [7:0] got);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, ~model_b[i], seen);
      got[i] = seen;
    end
    xfer_bit(~ack, 1'b0, seen);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       acked;
    logic       seen;
    logic [7:0] got;
    int         base;

    rst = 1'b1;
    tick(4);
    chk("reset_sda_oe",   32'(bus.sda_oe), 32'd0);
    chk("reset_rx_data",  32'(rx_data),    32'h00);
    chk("reset_rx_valid", 32'(rx_valid),   32'd0);
    chk("reset_tx_req",   32'(tx_req),     32'd0);
    chk("reset_rw_dir",   32'(rw_dir),     32'd0);
    chk("reset_busy",     32'(busy),       32'd0);
    chk("reset_state",    32'(state),      32'(IDLE));
    rst = 1'b0;
    tick(4);

    // Write 0xA5 to our address.
    bus_start();
    chk("wr_busy_after_start", 32'(busy), 32'd1);
    addr_phase(TB_ADDR, I2C_WRITE, acked);
    chk("wr_addr_acked", 32'(acked), 32'd1);
    write_byte(8'hA5, 1'b1);
    bus_stop();
    chk("wr_busy_after_stop", 32'(busy),    32'd0);
    chk("wr_rx_data",         32'(rx_data), 32'hA5);
    chk("wr_state_idle",      32'(state),   32'(IDLE));

    // Foreign address 0x53: no ACK, no data.
    bus_start();
    addr_phase(7'h53, I2C_WRITE, acked);
    chk("nack_addr_acked", 32'(acked), 32'd0);
    chk("nack_state_idle", 32'(state), 32'(IDLE));
    write_byte(8'h77, 1'b0);
    bus_stop();
    chk("nack_rx_data_kept", 32'(rx_data), 32'hA5);

    // Read two bytes, ACK the first and NACK the second.
    base = tx_req_cnt;
    bus_start();
    addr_phase(TB_ADDR, I2C_READ, acked);
    chk("rd_addr_acked", 32'(acked),  32'd1);
    chk("rd_rw_dir",     32'(rw_dir), 32'd1);
    read_byte(8'h3C, 1'b1, got);
    chk("rd_byte0", 32'(got), 32'h3C);
    read_byte(8'hC3, 1'b0, got);
    chk("rd_byte1", 32'(got), 32'hC3);
    chk("rd_sda_released", 32'(bus.sda_oe), 32'd0);
    chk("rd_state_idle",   32'(state),      32'(IDLE));
    bus_stop();
    chk("rd_tx_req_count", 32'(tx_req_cnt - base), 32'd2);

    // Repeated START after 4 data bits, then a clean write of 0x11.
    bus_start();
    addr_phase(TB_ADDR, I2C_WRITE, acked);
    for (int i = 0; i < 4; i++) xfer_bit(i[0], 1'b0, seen);
    bus_start();
    chk("rs_state_addr", 32'(state), 32'(ADDR));
    addr_phase(TB_ADDR, I2C_WRITE, acked);
    chk("rs_addr_acked", 32'(acked), 32'd1);
    write_byte(8'h11, 1'b1);
    bus_stop();
    chk("rs_rx_data", 32'(rx_data), 32'h11);

    // Reset while driving the first (zero) bit of a read byte.
    bus_start();
    addr_phase(TB_ADDR, I2C_READ, acked);
    scl = 1'b0;
    tick(2 * Q);
    chk("rst_pre_sda_oe", 32'(bus.sda_oe), 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_state",  32'(state),      32'(IDLE));
    rst = 1'b0;
    tick(4);
    chk("rst_rx_data_cleared", 32'(rx_data), 32'h00);
    bus_start();
    addr_phase(TB_ADDR, I2C_WRITE, acked);
    write_byte(8'h5A, 1'b1);
    bus_stop();
    chk("post_rst_rx_data", 32'(rx_data), 32'h5A);

    // STOP after 3 bits of a data byte.
    bus_start();
    addr_phase(TB_ADDR, I2C_WRITE, acked);
    xfer_bit(1'b1, 1'b0, seen);
    xfer_bit(1'b0, 1'b0, seen);
    xfer_bit(1'b1, 1'b0, seen);
    bus_stop();
    chk("stop_busy",    32'(busy),    32'd0);
    chk("stop_state",   32'(state),   32'(IDLE));
    chk("stop_rx_data", 32'(rx_data), 32'h5A);

    tick(4);
    chk("rx_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Responder end of the team's I2C link: a clk-synchronous I2C target (slave) that detects START/STOP and matches a 7-bit address.
- ACKs its own address, then either receives bytes from the initiator (write) or shifts out bytes supplied by the local side (read).
- Sits between the bus pins (open-drain SDA, SCL input only, no clock stretching) and a simple byte interface to local logic.
- clk oversamples SCL by at least 8x; all bus events are derived from synchronised edge detection.

Parameters:
- TARGET_ADDR, 7'h52, 7-bit bus address this target answers to.
- SYNC_STAGES, 2, flip-flop depth of the scl/sda input synchronisers (≥2).

Ports:
- clk  input  1  system clock (≥8x SCL frequency)
- rst  input  1  synchronous, active-high reset
- scl_in  input  1  bus SCL, asynchronous
- sda_in  input  1  bus SDA as seen on the pin, asynchronous
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
- rx_data  output  8  last byte received from initiator
- rx_valid  output  1  one-clk pulse: rx_data updated
- tx_data  input  8  byte to send on a read transfer
- tx_req  output  1  one-clk pulse: tx_data sampled; local side must present the next byte before the next tx_req
- rw_dir  output  1  R/W bit of the current transfer (1 = initiator reads)
- busy  output  1  high from START to STOP
- state  output  3  current FSM state, for debug

Behaviour:
- Reset values: sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, rw_dir=0, busy=0, state=IDLE. All shift registers and the bit counter are cleared.
- Input path: scl_in and sda_in each pass through SYNC_STAGES flops plus one history flop.
  - scl_rise / scl_fall: one-clk pulses on edges of synchronised SCL.
  - START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Sampling and driving:
  - SDA is sampled on scl_rise.
  - sda_oe changes only on the clk after scl_fall. It never changes while SCL is high.
- FSM states:
  - IDLE=0: wait for START.
  - ADDR=1: shift 8 bits MSB-first (7 address bits + R/W) on scl_rise.
  - ADDR_ACK=2: on the scl_fall after bit 8:
    - on match, sda_oe=1 for one SCL period, rw_dir latched, and tx_req pulses when rw_dir=1;
    - on mismatch, return to IDLE with sda_oe=0.
  - RX=3: shift 8 bits on scl_rise. After the 8th, rx_data is loaded and rx_valid pulses once.
  - RX_ACK=4: sda_oe=1 from the next scl_fall to the following scl_fall, then back to RX.
  - TX=5: drive bits MSB-first from the byte latched at tx_req, changing on scl_fall. sda_oe = ~bit.
  - TX_ACK=6: release SDA and sample the initiator's ACK on scl_rise:
    - ACK (0): latch the next tx_data, pulse tx_req, return to TX;
    - NACK (1): release and go to IDLE, waiting for STOP.
- Bit counter: 3-bit, wraps 7→0 at each byte boundary.
- START in any state, including repeated START mid-byte: abort the current byte, no rx_valid, sda_oe=0, go to ADDR, busy=1.
- STOP in any state: sda_oe=0 on the next clk, go to IDLE, busy=0. A partial byte is discarded.
- General call (address 0) is not acknowledged.
- rst asserted mid-transfer: immediate return to reset values. The bus is released within 1 clk.
- Simultaneous START detect and scl_fall in the same clk: START has priority.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings (IDLE..TX_ACK as 3-bit localparams);
  - I2C_READ=1 / I2C_WRITE=0 constants;
  - the default target address.
- One natural sub-module, i2c_bus_sync: synchroniser plus edge/START/STOP detector. It outputs scl_rise, scl_fall, sda_s, start_det, stop_det, and is reused by the initiator.

Test Plan:
- Write to 0x52 with data 0xA5 then STOP:
  - sda_oe=1 during the address ACK and the data ACK;
  - rx_valid pulses once with rx_data=8'hA5;
  - busy falls after STOP.
- Address 0x53 write:
  - no ACK (sda_oe stays 0 for the whole frame);
  - no rx_valid; FSM returns to IDLE after the 8th bit.
- Read from 0x52 with tx_data=0x3C, then 0xC3 after the tx_req, initiator ACKs byte 1 and NACKs byte 2:
  - bus shows 0x3C then 0xC3;
  - exactly 2 tx_req pulses; sda_oe=0 after the NACK.
- Repeated START after 4 data bits of a write, then a new write of 0x11:
  - no rx_valid for the aborted byte;
  - one rx_valid with rx_data=8'h11.
- rst pulsed during TX with sda_oe=1:
  - sda_oe=0 on the next clk, state=IDLE;
  - a subsequent valid write of 0x5A is received correctly.
- STOP after 3 bits of a data byte:
  - busy=0, no rx_valid, state=IDLE, rx_data unchanged.
